// File: rtl/hex_pkg.sv
// Package: hex_pkg
// Purpose: constants and types shared by the Intel-HEX sequencer, the
//          ASCII-to-hex decoder and the record datapath.
// Contents:
//   ADDR_W, BYTE_W, NIB_W - field widths
//   LRC_MOD               - modulus of the record longitudinal checksum
//   lrc_add()             - checksum accumulate step
package hex_pkg;

  localparam int ADDR_W  = 16;
  localparam int BYTE_W  = 8;
  localparam int NIB_W   = 4;
  localparam int LRC_MOD = 256;

  typedef logic [NIB_W-1:0]  nib_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // One checksum accumulate step: the record LRC is the byte sum modulo 256.
  function automatic byte_t lrc_add(input byte_t a, input byte_t b);
    return byte_t'((int'(a) + int'(b)) % LRC_MOD);
  endfunction

endpackage

// File: rtl/hex_byte_asm.sv
// Module: hex_byte_asm
// Purpose: assembles a byte from two nibbles. The high nibble is held in a
//          register on hi_le; the byte {held, nib} is presented while lo_le
//          is high, so the consumer captures it on that same edge.
// Ports:
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous active-high reset
//   clear      in   synchronous clear of the held nibble (record start)
//   nib        in   4-bit nibble
//   hi_le      in   latch nib as the high nibble
//   lo_le      in   nib is the low nibble, byte is valid this cycle
//   byte_val   out  assembled byte {held, nib}
//   byte_valid out  byte_val is valid this cycle
module hex_byte_asm
  import hex_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              clear,
  input  logic [NIB_W-1:0]  nib,
  input  logic              hi_le,
  input  logic              lo_le,
  output logic [BYTE_W-1:0] byte_val,
  output logic              byte_valid
);

  nib_t nib_hold;

  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff sees the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)        nib_hold <= '0;
    else if (clear) nib_hold <= '0;
    else if (hi_le) nib_hold <= nib;
  end

  assign byte_val   = {nib_hold, nib};
  assign byte_valid = lo_le;

endmodule

// File: rtl/hex_record_datapath.sv
// Module: hex_record_datapath
// Purpose: datapath behind the Intel-HEX record sequencer. Captures decoded
//          nibbles into the byte count, load address, data and received
//          checksum registers, accumulates the record LRC, drives the target
//          memory write port and reports TDC and per-record checksum result.
// Parameters:
//   ERR_STICKY  1: LRC_ERR_FLAG holds until CLR; 0: cleared by next SC
//   WRAP_ADDR   1: address wraps FFFF->0000; 0: saturates, sets ADDR_OVF
// Ports:
//   CLK, CLR      clock (rising) / asynchronous active-high reset
//   NIB           decoded nibble, valid while any load enable is high
//   SC            record start strobe
//   CLE, ALE, DLE byte count / address / data nibble load enables
//   LRCLE         [3:2] rx checksum hi/lo, [1:0] LRC accumulate hi/lo
//   DCE           one pulse per data byte written
//   WR            active-low write strobe from the sequencer
//   CMP           compare checksum at record end
//   TDC           remaining data byte count is zero
//   MEM_WE/ADDR/DATA  memory write port
//   LRC_OK/LRC_ERR    one-cycle checksum verdict
//   LRC_ERR_FLAG      checksum error indication
//   ADDR_OVF          sticky write-past-FFFF indication (WRAP_ADDR=0)
module hex_record_datapath
  import hex_pkg::*;
#(
  parameter bit ERR_STICKY = 1'b1,
  parameter bit WRAP_ADDR  = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NIB_W-1:0]  NIB,
  input  logic              SC,
  input  logic [1:0]        CLE,
  input  logic [3:0]        ALE,
  input  logic [1:0]        DLE,
  input  logic [3:0]        LRCLE,
  input  logic              DCE,
  input  logic              WR,
  input  logic              CMP,
  output logic              TDC,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [BYTE_W-1:0] MEM_DATA,
  output logic              LRC_OK,
  output logic              LRC_ERR,
  output logic              LRC_ERR_FLAG,
  output logic              ADDR_OVF
);

  // Only the high count nibble needs its own register: the full count is
  // copied into rem when the low nibble arrives.
  nib_t  cnt_hi;
  byte_t rem;
  addr_t addr_ptr;
  byte_t dreg;
  byte_t rx_lrc;
  byte_t lrc_sum;
  logic  lrc_ok_q;
  logic  lrc_err_q;
  logic  err_flag_q;
  logic  addr_ovf_q;

  byte_t acc_byte;
  logic  acc_valid;
  logic  lrc_bad;

  hex_byte_asm u_lrc_asm (
    .CLK        (CLK),
    .CLR        (CLR),
    .clear      (SC),
    .nib        (NIB),
    .hi_le      (LRCLE[1]),
    .lo_le      (LRCLE[0]),
    .byte_val   (acc_byte),
    .byte_valid (acc_valid)
  );

  // Sum of all record bytes including the received checksum must be zero.
  assign lrc_bad = (lrc_add(lrc_sum, rx_lrc) != '0);

  // Record fields, checksum accumulator and compare. SC wins over every load
  // enable; the compare samples pre-SC values, so CMP and SC may coincide.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt_hi     <= '0;
      rem        <= '0;
      dreg       <= '0;
      rx_lrc     <= '0;
      lrc_sum    <= '0;
      lrc_ok_q   <= 1'b0;
      lrc_err_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      lrc_ok_q  <= CMP & ~lrc_bad;
      lrc_err_q <= CMP &  lrc_bad;

      // An error reported on this edge takes precedence over an SC clear.
      if (CMP && lrc_bad)      err_flag_q <= 1'b1;
      else if (SC && !ERR_STICKY) err_flag_q <= 1'b0;

      if (SC) begin
        cnt_hi  <= '0;
        rem     <= '0;
        rx_lrc  <= '0;
        lrc_sum <= '0;
      end else begin
        if (CLE[1]) cnt_hi <= NIB;
        if (CLE[0])                rem <= {cnt_hi, NIB};
        else if (DCE && rem != '0) rem <= rem - 1'b1;
        if (LRCLE[3]) rx_lrc[7:4] <= NIB;
        if (LRCLE[2]) rx_lrc[3:0] <= NIB;
        if (acc_valid) lrc_sum <= lrc_add(lrc_sum, acc_byte);
        if (DLE[1]) dreg[7:4] <= NIB;
        if (DLE[0]) dreg[3:0] <= NIB;
      end
    end
  end

  // Address pointer: nibble loads beat the post-write increment.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      addr_ptr   <= '0;
      addr_ovf_q <= 1'b0;
    end else if (!SC && ALE != '0) begin
      for (int k = 0; k < 4; k++)
        if (ALE[k]) addr_ptr[4*k +: 4] <= NIB;
    end else if (!WR) begin
      if (addr_ptr == '1) begin
        if (WRAP_ADDR) addr_ptr   <= '0;
        else           addr_ovf_q <= 1'b1;
      end else begin
        addr_ptr <= addr_ptr + 1'b1;
      end
    end
  end

  assign TDC          = (rem == '0);
  // NOTE: the write enable is combinational from WR, so it is gated with CLR
  // to give the same reset value as the registered outputs.
  assign MEM_WE       = ~WR & ~CLR;
  assign MEM_ADDR     = addr_ptr;
  assign MEM_DATA     = dreg;
  assign LRC_OK       = lrc_ok_q;
  assign LRC_ERR      = lrc_err_q;
  assign LRC_ERR_FLAG = err_flag_q;
  assign ADDR_OVF     = addr_ovf_q;

endmodule

// File: tb/tb_hex_record_datapath.sv
// Bench for hex_record_datapath. Two instances share the stimulus:
// u_a (ERR_STICKY=1, WRAP_ADDR=1) and u_b (ERR_STICKY=0, WRAP_ADDR=0).
// Records are given as byte lists; the bench model derives the expected
// writes from the start address, the checksum verdict from the byte sum
// and the remaining-count from the bytes written so far.
module tb_hex_record_datapath;

  typedef logic [7:0] rec_t [$];
  typedef enum {K_CNT, K_ADDR, K_TYPE, K_DATA, K_CS} kind_e;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] NIB;
  logic       SC;
  logic [1:0] CLE;
  logic [3:0] ALE;
  logic [1:0] DLE;
  logic [3:0] LRCLE;
  logic       DCE, WR, CMP;

  logic        TDC_a, MEM_WE_a, LRC_OK_a, LRC_ERR_a, LRC_ERR_FLAG_a, ADDR_OVF_a;
  logic [15:0] MEM_ADDR_a;
  logic [7:0]  MEM_DATA_a;
  logic        TDC_b, MEM_WE_b, LRC_OK_b, LRC_ERR_b, LRC_ERR_FLAG_b, ADDR_OVF_b;
  logic [15:0] MEM_ADDR_b;
  logic [7:0]  MEM_DATA_b;

  hex_record_datapath #(.ERR_STICKY(1'b1), .WRAP_ADDR(1'b1)) u_a (
    .CLK(CLK), .CLR(CLR), .NIB(NIB), .SC(SC), .CLE(CLE), .ALE(ALE), .DLE(DLE),
    .LRCLE(LRCLE), .DCE(DCE), .WR(WR), .CMP(CMP),
    .TDC(TDC_a), .MEM_WE(MEM_WE_a), .MEM_ADDR(MEM_ADDR_a), .MEM_DATA(MEM_DATA_a),
    .LRC_OK(LRC_OK_a), .LRC_ERR(LRC_ERR_a), .LRC_ERR_FLAG(LRC_ERR_FLAG_a),
    .ADDR_OVF(ADDR_OVF_a)
  );

  hex_record_datapath #(.ERR_STICKY(1'b0), .WRAP_ADDR(1'b0)) u_b (
    .CLK(CLK), .CLR(CLR), .NIB(NIB), .SC(SC), .CLE(CLE), .ALE(ALE), .DLE(DLE),
    .LRCLE(LRCLE), .DCE(DCE), .WR(WR), .CMP(CMP),
    .TDC(TDC_b), .MEM_WE(MEM_WE_b), .MEM_ADDR(MEM_ADDR_b), .MEM_DATA(MEM_DATA_b),
    .LRC_OK(LRC_OK_b), .LRC_ERR(LRC_ERR_b), .LRC_ERR_FLAG(LRC_ERR_FLAG_b),
    .ADDR_OVF(ADDR_OVF_b)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  bit          chk_en = 1'b0;
  int          exp_rem = 0;
  logic [15:0] ptr_a = '0, ptr_b = '0;
  logic [15:0] exp_addr_a, exp_addr_b;
  logic [7:0]  exp_data;
  bit          exp_we = 1'b0, exp_ok = 1'b0, exp_err = 1'b0;
  bit          flag_a = 1'b0, flag_b = 1'b0, ovf_b = 1'b0;

  // observation logs for the hand-computed pins
  logic [23:0] wlog_a [$];
  logic [23:0] wlog_b [$];
  int ok_cnt_a = 0, err_cnt_a = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("tdc_a", TDC_a, exp_rem == 0);
      check("tdc_b", TDC_b, exp_rem == 0);
      check("we_a", MEM_WE_a, exp_we);
      check("we_b", MEM_WE_b, exp_we);
      if (exp_we) begin
        check("addr_a", MEM_ADDR_a, exp_addr_a);
        check("addr_b", MEM_ADDR_b, exp_addr_b);
        check("data_a", MEM_DATA_a, exp_data);
        check("data_b", MEM_DATA_b, exp_data);
      end
      check("ok_a", LRC_OK_a, exp_ok);
      check("ok_b", LRC_OK_b, exp_ok);
      check("err_a", LRC_ERR_a, exp_err);
      check("err_b", LRC_ERR_b, exp_err);
      check("flag_a", LRC_ERR_FLAG_a, flag_a);
      check("flag_b", LRC_ERR_FLAG_b, flag_b);
      check("ovf_a", ADDR_OVF_a, 1'b0);
      check("ovf_b", ADDR_OVF_b, ovf_b);
      if (MEM_WE_a) wlog_a.push_back({MEM_ADDR_a, MEM_DATA_a});
      if (MEM_WE_b) wlog_b.push_back({MEM_ADDR_b, MEM_DATA_b});
      if (LRC_OK_a)  ok_cnt_a++;
      if (LRC_ERR_a) err_cnt_a++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    SC = 1'b0; CLE = '0; ALE = '0; DLE = '0; LRCLE = '0;
    DCE = 1'b0; WR = 1'b1; CMP = 1'b0; NIB = '0;
    exp_we = 1'b0; exp_ok = 1'b0; exp_err = 1'b0;
  endtask

  task automatic start_record();
    SC = 1'b1;
    tick();
    exp_rem = 0;
    flag_b  = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] v, input kind_e kind, input bit lo_addr);
    NIB = v[7:4];
    case (kind)
      K_CNT:  CLE = 2'b10;
      K_ADDR: ALE = lo_addr ? 4'b0010 : 4'b1000;
      K_DATA: DLE = 2'b10;
      K_CS:   LRCLE[3] = 1'b1;
      default: ;
    endcase
    if (kind != K_CS) LRCLE[1] = 1'b1;
    tick();
    NIB = v[3:0];
    case (kind)
      K_CNT:  CLE = 2'b01;
      K_ADDR: ALE = lo_addr ? 4'b0001 : 4'b0100;
      K_DATA: DLE = 2'b01;
      K_CS:   LRCLE[2] = 1'b1;
      default: ;
    endcase
    if (kind != K_CS) LRCLE[0] = 1'b1;
    tick();
    if (kind == K_CNT) exp_rem = int'(v);
  endtask

  task automatic write_byte(input logic [7:0] v);
    WR = 1'b0; DCE = 1'b1;
    exp_we = 1'b1; exp_data = v; exp_addr_a = ptr_a; exp_addr_b = ptr_b;
    tick();
    ptr_a = ptr_a + 16'd1;
    if (ptr_b == 16'hFFFF) ovf_b = 1'b1;
    else                   ptr_b = ptr_b + 16'd1;
    if (exp_rem > 0) exp_rem--;
  endtask

  // Sends a whole record. abort_after>0 stops after that many data writes.
  task automatic send_rec(input rec_t r, input bit skip_sc, input bit cmp_with_sc,
                          input int abort_after);
    int n;
    int sum;
    n = int'(r[0]);
    sum = 0;
    foreach (r[i]) sum += int'(r[i]);
    if (!skip_sc) start_record();
    load_byte(r[0], K_CNT, 1'b0);
    load_byte(r[1], K_ADDR, 1'b0);
    load_byte(r[2], K_ADDR, 1'b1);
    ptr_a = {r[1], r[2]};
    ptr_b = {r[1], r[2]};
    load_byte(r[3], K_TYPE, 1'b0);
    for (int i = 0; i < n; i++) begin
      load_byte(r[4+i], K_DATA, 1'b0);
      write_byte(r[4+i]);
      if (i + 1 == abort_after) return;
    end
    load_byte(r[4+n], K_CS, 1'b0);
    CMP = 1'b1;
    if (cmp_with_sc) SC = 1'b1;
    tick();
    exp_ok  = (sum % 256) == 0;
    exp_err = !exp_ok;
    if (cmp_with_sc) begin
      exp_rem = 0;
      if (!exp_err) flag_b = 1'b0;
    end
    if (exp_err) begin
      flag_a = 1'b1;
      flag_b = 1'b1;
    end
    tick();
  endtask

  // ---------------- test sequence ----------------
  rec_t r_good = '{8'h03, 8'h00, 8'h30, 8'h00, 8'h02, 8'h33, 8'h7A, 8'h1E};
  rec_t r_bad  = '{8'h03, 8'h00, 8'h30, 8'h00, 8'h02, 8'h33, 8'h7A, 8'h1F};
  rec_t r_eof  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
  rec_t r_wrap = '{8'h02, 8'hFF, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'h01};

  initial begin
    CLR = 1'b1;
    SC = 1'b0; CLE = '0; ALE = '0; DLE = '0; LRCLE = '0;
    DCE = 1'b0; WR = 1'b1; CMP = 1'b0; NIB = '0;
    #3;
    check("rst_tdc", TDC_a, 1'b1);
    check("rst_we", MEM_WE_a, 1'b0);
    check("rst_addr", MEM_ADDR_a, 16'h0000);
    check("rst_data", MEM_DATA_a, 8'h00);
    check("rst_ok", LRC_OK_a, 1'b0);
    check("rst_err", LRC_ERR_a, 1'b0);
    check("rst_flag", LRC_ERR_FLAG_a, 1'b0);
    check("rst_ovf", ADDR_OVF_b, 1'b0);
    tick();
    tick();
    CLR = 1'b0;
    chk_en = 1'b1;
    tick();

    // 1: good data record
    wlog_a.delete();
    send_rec(r_good, 1'b0, 1'b0, -1);
    check("t1_nwr", wlog_a.size(), 3);
    check("t1_w0", wlog_a[0], 24'h003002);
    check("t1_w1", wlog_a[1], 24'h003133);
    check("t1_w2", wlog_a[2], 24'h00327A);
    check("t1_okcnt", ok_cnt_a, 1);

    // 2: bad checksum, then a good record
    send_rec(r_bad, 1'b0, 1'b0, -1);
    check("t2_errcnt", err_cnt_a, 1);
    check("t2_flag_b", LRC_ERR_FLAG_b, 1'b1);
    send_rec(r_good, 1'b0, 1'b0, -1);
    check("t2_sticky_a", LRC_ERR_FLAG_a, 1'b1);
    check("t2_clear_b", LRC_ERR_FLAG_b, 1'b0);

    // 3: end-of-file record, zero length
    wlog_a.delete();
    send_rec(r_eof, 1'b0, 1'b0, -1);
    check("t3_nwr", wlog_a.size(), 0);
    check("t3_okcnt", ok_cnt_a, 3);

    // 4: address wrap / saturation
    wlog_a.delete();
    wlog_b.delete();
    send_rec(r_wrap, 1'b0, 1'b0, -1);
    check("t4_a_w0", wlog_a[0], 24'hFFFFAA);
    check("t4_a_w1", wlog_a[1], 24'h000055);
    check("t4_b_w0", wlog_b[0], 24'hFFFFAA);
    check("t4_b_w1", wlog_b[1], 24'hFFFF55);
    check("t4_ovf_b", ADDR_OVF_b, 1'b1);

    // 5: reset in the middle of a record
    send_rec(r_good, 1'b0, 1'b0, 2);
    CLR = 1'b1;
    ptr_a = '0; ptr_b = '0; flag_a = 1'b0; flag_b = 1'b0; ovf_b = 1'b0;
    exp_rem = 0; exp_we = 1'b0; exp_ok = 1'b0; exp_err = 1'b0;
    #1;
    check("t5_tdc", TDC_a, 1'b1);
    check("t5_addr", MEM_ADDR_a, 16'h0000);
    check("t5_data", MEM_DATA_a, 8'h00);
    check("t5_flag_a", LRC_ERR_FLAG_a, 1'b0);
    check("t5_ovf_b", ADDR_OVF_b, 1'b0);
    tick();
    CLR = 1'b0;
    tick();
    send_rec(r_good, 1'b0, 1'b0, -1);
    check("t5_okcnt", ok_cnt_a, 5);

    // 6: CMP coincident with the next record's SC
    send_rec(r_good, 1'b0, 1'b1, -1);
    send_rec(r_eof, 1'b1, 1'b0, -1);
    check("t6_okcnt", ok_cnt_a, 7);
    check("t6_errcnt", err_cnt_a, 1);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
